// File: rtl/ws2811_rx_if.sv
// ws2811_rx byte output port: valid/ready handshake carrying one decoded byte.
interface ws2811_rx_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ws2811_rx.sv
// WS2811 line decoder: classifies high-pulse widths into bits, packs bytes,
// detects the latch gap and reports line faults as single-cycle pulses.
module ws2811_rx #(
  parameter int THRESH_CYC   = 38,
  parameter int MIN_HIGH_CYC = 6,
  parameter int MAX_HIGH_CYC = 120,
  parameter int RESET_CYC    = 3000,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        din,
  ws2811_rx_if.master out_if,
  output logic        frame_end,
  output logic        frame_err,
  output logic        err_glitch,
  output logic        err_long,
  output logic        overrun,
  output logic [15:0] byte_count
);

  localparam int CW = $clog2(RESET_CYC + 1);
  localparam logic [CW-1:0] RST_C  = CW'(RESET_CYC);
  localparam logic [CW-1:0] GAP_C  = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] THR_C  = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_HIGH_CYC);
  localparam logic [CW-1:0] MAXM_C = CW'(MAX_HIGH_CYC - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          s1_q, din_s_q, prev_q;
  logic [CW-1:0] low_q, low_d;
  logic [CW-1:0] high_q, high_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [15:0]   bc_q, bc_d;
  logic          arm_q, arm_d;
  logic          fe_q, fe_d;
  logic          fr_q, fr_d;
  logic          gl_q, gl_d;
  logic          lg_q, lg_d;
  logic          ov_q, ov_d;

  logic rise, fall, hs, bit_en, bit_v;

  assign rise = din_s_q & ~prev_q;
  assign fall = ~din_s_q & prev_q;
  assign hs   = valid_q & out_if.out_ready;

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    high_d  = high_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    bc_d    = bc_q;
    arm_d   = arm_q;
    fe_d    = 1'b0;
    fr_d    = 1'b0;
    gl_d    = 1'b0;
    lg_d    = 1'b0;
    ov_d    = 1'b0;
    bit_en  = 1'b0;
    bit_v   = 1'b0;

    if (hs) valid_d = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (din_s_q) begin
          low_d = '0;
        end else if (low_q == GAP_C) begin
          state_d = LOW;
          low_d   = '0;
        end else begin
          low_d = low_q + ONE_C;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = ONE_C;
          if (arm_q) begin
            bc_d  = '0;
            arm_d = 1'b0;
          end
        end else begin
          // Saturation makes the gap fire only once per low period
          if (low_q != RST_C) low_d = low_q + ONE_C;
          if (low_q == GAP_C) begin
            if (bit_q != 3'd0) fr_d = 1'b1;
            else if (bc_q != 16'd0 && !arm_q) fe_d = 1'b1;
            bit_d = 3'd0;
            arm_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          if (high_q < MIN_C) begin
            gl_d    = 1'b1;
            bit_d   = 3'd0;
            arm_d   = 1'b1;
            low_d   = '0;
            state_d = SYNC;
          end else begin
            bit_en  = 1'b1;
            low_d   = ONE_C;
            state_d = LOW;
          end
        end else if (high_q == MAXM_C) begin
          lg_d    = 1'b1;
          bit_d   = 3'd0;
          arm_d   = 1'b1;
          low_d   = '0;
          state_d = SYNC;
        end else begin
          high_d = high_q + ONE_C;
        end
      end
      default: state_d = SYNC;
    endcase

    if (bit_en) begin
      bit_v = (high_q >= THR_C);
      sh_d  = LSB_FIRST ? {bit_v, sh_q[7:1]} : {sh_q[6:0], bit_v};
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        if (bc_q != 16'hFFFF) bc_d = bc_q + 16'd1;
        // A full register being drained this cycle can still take the byte
        if (!valid_q || hs) begin
          data_d  = sh_d;
          valid_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s1_q    <= 1'b0;
      din_s_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= SYNC;
      low_q   <= '0;
      high_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      bc_q    <= 16'd0;
      arm_q   <= 1'b0;
      fe_q    <= 1'b0;
      fr_q    <= 1'b0;
      gl_q    <= 1'b0;
      lg_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      s1_q    <= din;
      din_s_q <= s1_q;
      prev_q  <= din_s_q;
      state_q <= state_d;
      low_q   <= low_d;
      high_q  <= high_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bc_q    <= bc_d;
      arm_q   <= arm_d;
      fe_q    <= fe_d;
      fr_q    <= fr_d;
      gl_q    <= gl_d;
      lg_q    <= lg_d;
      ov_q    <= ov_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign frame_end        = fe_q;
  assign frame_err        = fr_q;
  assign err_glitch       = gl_q;
  assign err_long         = lg_q;
  assign overrun          = ov_q;
  assign byte_count       = bc_q;

endmodule

// File: tb/tb_ws2811_rx.sv
// Directed bench for ws2811_rx: bytes, gaps, overrun, glitch,
// stuck-high, partial frame and mid-byte reset.
module tb_ws2811_rx;

  logic        clk = 1'b0;
  logic        rst_;
  logic        din;
  logic        frame_end, frame_err, err_glitch, err_long, overrun;
  logic [15:0] byte_count;

  ws2811_rx_if bus ();

  ws2811_rx dut (
    .clk        (clk),
    .rst_       (rst_),
    .din        (din),
    .out_if     (bus),
    .frame_end  (frame_end),
    .frame_err  (frame_err),
    .err_glitch (err_glitch),
    .err_long   (err_long),
    .overrun    (overrun),
    .byte_count (byte_count)
  );

  always #8 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int vcyc, fe_n, fr_n, gl_n, lg_n, ov_n;
  logic [7:0] hs_q[$];

  always @(negedge clk) begin
    if (rst_) begin
      if (bus.out_valid) vcyc++;
      if (bus.out_valid && bus.out_ready) hs_q.push_back(bus.out_data);
      if (frame_end)  fe_n++;
      if (frame_err)  fr_n++;
      if (err_glitch) gl_n++;
      if (err_long)   lg_n++;
      if (overrun)    ov_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    vcyc = 0; fe_n = 0; fr_n = 0;
    gl_n = 0; lg_n = 0; ov_n = 0;
    hs_q.delete();
  endtask

  task automatic expect_hs(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (hs_q.size() != 0) ? {24'd0, hs_q.pop_front()} : 32'hDEAD;
    check(tag, got, {24'd0, exp});
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b ? 56 : 19);
    drive(1'b0, b ? 19 : 56);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] c3;
    clr();
    rst_ = 1'b0;
    din  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_bcnt", {16'd0, byte_count}, 32'd0);
    check("rst_pulses", {27'd0, frame_end, frame_err, err_glitch,
                         err_long, overrun}, 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    drive(1'b0, 3100);

    // Single byte A5 with exact output latency
    clr();
    a5 = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(a5[i]);
    drive(1'b1, 56);
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_lat_pre", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("t1_lat_edge3", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b0, 19);
    check("t1_vcyc", vcyc, 1);
    expect_hs("t1_data", 8'hA5);
    check("t1_bcnt", {16'd0, byte_count}, 32'd1);
    check("t1_errs", gl_n + lg_n + ov_n + fr_n + fe_n, 0);
    drive(1'b0, 3100);
    check("t1_fe", fe_n, 1);

    // Three bytes then gap; next frame clears byte_count on first rise
    clr();
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h80);
    check("t2_fe_early", fe_n, 0);
    drive(1'b0, 3100);
    check("t2_hs_n", hs_q.size(), 3);
    expect_hs("t2_d0", 8'h01);
    expect_hs("t2_d1", 8'hFF);
    expect_hs("t2_d2", 8'h80);
    check("t2_fe", fe_n, 1);
    check("t2_bcnt", {16'd0, byte_count}, 32'd3);
    c3 = 8'hC3;
    drive(1'b1, 6);
    @(negedge clk);
    check("t2_bcnt_clr", {16'd0, byte_count}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 49);
    drive(1'b0, 19);
    for (int i = 1; i < 8; i++) send_bit(c3[i]);
    check("t2_bcnt_new", {16'd0, byte_count}, 32'd1);
    expect_hs("t2_d3", 8'hC3);
    drive(1'b0, 3100);

    // Overrun: consumer stalled across two bytes
    clr();
    bus.out_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    check("t3_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_hold", {24'd0, bus.out_data}, 32'h11);
    check("t3_ov", ov_n, 1);
    check("t3_bcnt", {16'd0, byte_count}, 32'd2);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b0, 10);
    check("t3_hs_n", hs_q.size(), 1);
    expect_hs("t3_data", 8'h11);
    check("t3_valid_off", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 3100);

    // Glitch: following byte ignored until a full gap
    clr();
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("t4_glitch", gl_n, 1);
    send_byte(8'hFF);
    drive(1'b0, 3100);
    check("t4_ignored", hs_q.size(), 0);
    send_byte(8'h5A);
    check("t4_fe_early", fe_n, 0);
    drive(1'b0, 3100);
    check("t4_hs_n", hs_q.size(), 1);
    expect_hs("t4_data", 8'h5A);
    check("t4_fe", fe_n, 1);
    check("t4_glitch_once", gl_n, 1);

    // Stuck high line
    clr();
    drive(1'b1, 200);
    drive(1'b0, 10);
    check("t5_long", lg_n, 1);
    check("t5_nobyte", vcyc, 0);
    check("t5_noglitch", gl_n, 0);
    drive(1'b0, 3100);
    send_byte(8'h96);
    drive(1'b0, 3100);
    expect_hs("t5_data", 8'h96);
    check("t5_long_once", lg_n, 1);

    // Partial frame: 5 bits then gap
    clr();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    drive(1'b0, 3100);
    check("t6_ferr", fr_n, 1);
    check("t6_nofe", fe_n, 0);
    check("t6_novalid", vcyc, 0);

    // Reset mid-byte with a full holding register
    clr();
    bus.out_ready = 1'b0;
    send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    drive(1'b1, 20);
    @(negedge clk);
    check("t7_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t7_pre_data", {24'd0, bus.out_data}, 32'h77);
    #2;
    rst_ = 1'b0;
    #1;
    check("t7_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t7_rst_data", {24'd0, bus.out_data}, 32'd0);
    check("t7_rst_bcnt", {16'd0, byte_count}, 32'd0);
    @(posedge clk); #1;
    din  = 1'b0;
    rst_ = 1'b1;
    bus.out_ready = 1'b1;
    clr();
    send_byte(8'h3C);
    check("t7_sync_ignores", hs_q.size(), 0);
    drive(1'b0, 3100);
    send_byte(8'hE7);
    expect_hs("t7_recover", 8'hE7);
    check("t7_bcnt", {16'd0, byte_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #(16 * 80000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
